pipe_scoreboard: RTL
====================

# pipe_scoreboard

Parametrised register scoreboard and forwarding-select unit for the RV32I pipeline, sitting beside the hazard control unit between decode and the downstream stage registers. It mirrors the destination-register state of every post-decode stage in its own shift chain, which advances under the same per-stage load enables and flushes as the datapath registers. Each cycle it resolves read-after-write dependencies of the decoding instruction into per-source forward selects or a decode stall. Stage count, source count, load-data availability stage and forwarding mode are generic.

## Interface
- NUM_STAGES, 3: tracked post-decode stages; stage 0 = EX, stage NUM_STAGES-1 = last before retire.
- NUM_SRC, 2: source operands per instruction.
- REG_AW, 5: register address width.
- LOAD_STAGE, 1: first stage index where load data is forwardable.
- FWD_EN, 1: 1 = forwarding mode; 0 = stall-only mode.
- FWD_W is derived as $clog2(NUM_STAGES+1); CNT_W is derived as $clog2(NUM_STAGES+1).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source registers; src s at bits [s*REG_AW +: REG_AW].
- id_rd  in  REG_AW  destination register.
- id_wen  in  1  decode instruction writes id_rd.
- id_is_load  in  1  decode instruction is a load.
- stage_load  in  NUM_STAGES  per-stage advance enable from hazard control.
- flush  in  NUM_STAGES  per-stage bubble insert.
- stall_id  out  1  hold decode; unresolvable RAW hazard.
- fwd_sel  out  NUM_SRC*FWD_W  per source: 0 = register file, k = stage k-1.
- inflight_cnt  out  CNT_W  count of tracked entries that will write a nonzero register.

## Operation
- Entry per stage: {valid, wen, is_load, rd}. Bubble = all fields zero.
- Update per stage i (priority order):
  - flush[i]=1: bubble.
  - Else stage_load[i]=0: hold.
  - Else i=0: capture {id_valid & ~stall_id, id_wen, id_is_load, id_rd}.
  - Else stage_load[i-1]=1: capture entry[i-1].
  - Else: bubble, because the upstream stage is held.
- The last entry retires whenever its stage reloads.
- Match for source s at stage k: entry valid, wen=1, rd == rs_s, rs_s != 0. Register x0 never matches.
- Resolution per source: scan k = 0 upward; the first (youngest) match wins.
  - No match: fwd 0.
  - FWD_EN=0: any match sets stall; fwd stays 0.
  - FWD_EN=1, match is_load and k < LOAD_STAGE: stall.
  - Otherwise: fwd = k+1.
- stall_id = id_valid & OR over sources of the per-source stall.
- fwd_sel is forced to 0 while stall_id=1 or id_valid=0.
- inflight_cnt = popcount over stages of (valid & wen & rd != 0).

## Timing
- stall_id, fwd_sel and inflight_cnt are combinational from the current entries and ID inputs; zero-cycle latency, no registered outputs.
- Entry updates take effect on the clock edge after the enables are sampled; one cycle of latency per stage hop.
- Reset (rst=0, asynchronous assert):
  - All entries are bubbles immediately.
  - stall_id=0, fwd_sel=0 and inflight_cnt=0 regardless of inputs.
  - Deassertion is sampled at the next rising edge; the first capture occurs on the first edge with rst=1.
- A decode stall inserts exactly one bubble into stage 0 per stalled cycle, provided stage_load[0]=1.
- flush and stage_load together on the same stage: flush wins.
- Simultaneous flush of all stages: every entry becomes a bubble; inflight_cnt=0 next cycle.
- Same rd in several stages: the youngest stage is selected; older copies are ignored.
- All stage_load=0: full freeze; outputs are re-evaluated only from ID input changes.

## Test plan
- Reset: hold rst=0 with id_valid=1, id_rs={x1,x1} and entries previously nonzero -> stall_id=0, fwd_sel=0, inflight_cnt=0. Release rst; first edge captures normally.
- ALU back-to-back (defaults, stage_load=3'b111):
  - Cycle 0: decode add x5.
  - Cycle 1: decode rs1=x5, rs2=x2 -> fwd_sel src0=1, src1=0, stall_id=0.
  - Cycle 2 with the consumer moved on: inflight_cnt=1.
- Load-use:
  - lw x6 enters stage 0; decode rs2=x6 -> stall_id=1, fwd_sel=0.
  - Next edge with all loads high: stage 0 = bubble, stage 1 = lw, so stall_id=0 and src1 fwd_sel=2.
- Youngest wins and x0:
  - x7 writers in stage 0 and stage 2; decode rs1=x7 -> fwd_sel src0=1.
  - Decode rs1=x0 with an x0 writer present -> fwd_sel 0, no stall; the x0 writer is excluded from inflight_cnt.
- Flush/hold bubbles:
  - With stage_load=3'b101, the stage 1 entry is held and stage 2 receives a bubble.
  - flush=3'b001 with stage_load[0]=1 -> stage 0 is a bubble and inflight_cnt drops by 1.
- FWD_EN=0: an x9 writer in stage 2 with decode rs1=x9 -> stall_id=1, fwd_sel=0; the stall clears on the edge the entry retires.

Source files
------------

// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard
//
// Register scoreboard and forwarding-select unit for an RV32I pipeline.
// A shadow chain mirrors the destination-register state of every post-decode
// stage. It advances under the same per-stage load enables and flushes as the
// datapath registers. Each cycle the decoding instruction's sources are
// checked against the chain. The result is a per-source forward select, or a
// decode stall when the producing value is not yet available.
//
// Parameters
//   NUM_STAGES  tracked post-decode stages (0 = EX, NUM_STAGES-1 = last)
//   NUM_SRC     source operands per instruction
//   REG_AW      register address width
//   LOAD_STAGE  first stage index whose load data can be forwarded
//   FWD_EN      1 = forwarding, 0 = stall on any dependency
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   id_valid      decode holds a real instruction
//   id_rs         packed source registers, src s at [s*REG_AW +: REG_AW]
//   id_rd         decode destination register
//   id_wen        decode instruction writes id_rd
//   id_is_load    decode instruction is a load
//   stage_load    per-stage advance enable
//   flush         per-stage bubble insert (wins over stage_load)
//   stall_id      hold decode, unresolvable RAW hazard
//   fwd_sel       per source: 0 = register file, k = stage k-1
//   inflight_cnt  tracked entries that will write a nonzero register
// ---------------------------------------------------------------------------
module pipe_scoreboard #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_SRC    = 2,
   parameter int REG_AW     = 5,
   parameter int LOAD_STAGE = 1,
   parameter int FWD_EN     = 1,
   localparam int FWD_W     = $clog2(NUM_STAGES + 1),
   localparam int CNT_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_valid,
   input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]           id_rd,
   input  logic                        id_wen,
   input  logic                        id_is_load,
   input  logic [NUM_STAGES-1:0]       stage_load,
   input  logic [NUM_STAGES-1:0]       flush,
   output logic                        stall_id,
   output logic [NUM_SRC*FWD_W-1:0]    fwd_sel,
   output logic [CNT_W-1:0]            inflight_cnt
);

   // Shadow entries, one per tracked stage. A bubble has every field zero.
   logic [NUM_STAGES-1:0] ent_valid;
   logic [NUM_STAGES-1:0] ent_wen;
   logic [NUM_STAGES-1:0] ent_load;
   logic [REG_AW-1:0]     ent_rd [NUM_STAGES];

   logic [NUM_SRC-1:0]       src_stall;
   logic [NUM_SRC*FWD_W-1:0] fwd_raw;
   logic [CNT_W-1:0]         cnt_acc;

   // ---- shift chain update ------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_valid <= '0;
         ent_wen   <= '0;
         ent_load  <= '0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            ent_rd[i] <= '0;
         end
      end else begin
         // Stage 0 captures from decode; a stalled decode becomes a bubble.
         if (flush[0]) begin
            ent_valid[0] <= 1'b0;
            ent_wen[0]   <= 1'b0;
            ent_load[0]  <= 1'b0;
            ent_rd[0]    <= '0;
         end else if (stage_load[0]) begin
            ent_valid[0] <= id_valid & ~stall_id;
            ent_wen[0]   <= id_wen;
            ent_load[0]  <= id_is_load;
            ent_rd[0]    <= id_rd;
         end
         for (int i = 1; i < NUM_STAGES; i++) begin
            if (flush[i]) begin
               ent_valid[i] <= 1'b0;
               ent_wen[i]   <= 1'b0;
               ent_load[i]  <= 1'b0;
               ent_rd[i]    <= '0;
            end else if (stage_load[i]) begin
               if (stage_load[i-1]) begin
                  ent_valid[i] <= ent_valid[i-1];
                  ent_wen[i]   <= ent_wen[i-1];
                  ent_load[i]  <= ent_load[i-1];
                  ent_rd[i]    <= ent_rd[i-1];
               end else begin
                  // Upstream stage is held, so this stage receives a bubble.
                  ent_valid[i] <= 1'b0;
                  ent_wen[i]   <= 1'b0;
                  ent_load[i]  <= 1'b0;
                  ent_rd[i]    <= '0;
               end
            end
         end
      end
   end

   // ---- hazard resolution -------------------------------------------------
   // Scanning from the oldest stage down to the youngest lets the youngest
   // match overwrite any older one.
   always_comb begin
      src_stall = '0;
      fwd_raw   = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_wen[k] &&
                (ent_rd[k] == id_rs[s*REG_AW +: REG_AW]) &&
                (id_rs[s*REG_AW +: REG_AW] != '0)) begin
               if ((FWD_EN == 0) || (ent_load[k] && (k < LOAD_STAGE))) begin
                  src_stall[s]              = 1'b1;
                  fwd_raw[s*FWD_W +: FWD_W] = '0;
               end else begin
                  src_stall[s]              = 1'b0;
                  fwd_raw[s*FWD_W +: FWD_W] = FWD_W'(k + 1);
               end
            end
         end
      end
   end

   // Reset gating keeps the outputs quiet even while decode inputs are live.
   assign stall_id = rst & id_valid & (|src_stall);
   assign fwd_sel  = (!rst || !id_valid || stall_id) ? '0 : fwd_raw;

   // ---- in-flight writer count -------------------------------------------
   always_comb begin
      cnt_acc = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (ent_valid[k] && ent_wen[k] && (ent_rd[k] != '0)) begin
            cnt_acc = cnt_acc + CNT_W'(1);
         end
      end
   end

   assign inflight_cnt = rst ? cnt_acc : '0;

endmodule
